// File: rtl/vga_display_engine.sv
// VGA display engine: pixel-enable divider, H/V timing counters and a 2-tick colour/sync pipeline.
// Outputs change only on pixel ticks; no backpressure. Colour source is latched once per frame.
module vga_display_engine #(
    parameter int              H_VIS     = 640,
    parameter int              H_FP      = 16,
    parameter int              H_SYNC    = 96,
    parameter int              H_BP      = 48,
    parameter int              V_VIS     = 480,
    parameter int              V_FP      = 10,
    parameter int              V_SYNC    = 2,
    parameter int              V_BP      = 33,
    parameter int              CLK_DIV   = 4,
    parameter int              CW        = 12,
    parameter logic            SYNC_POL  = 1'b0,
    parameter logic [CW-1:0]   COL_START = 12'h00F,
    parameter logic [CW-1:0]   COL_LOSE  = 12'hF00,
    localparam int             H_TOT     = H_VIS + H_FP + H_SYNC + H_BP,
    localparam int             V_TOT     = V_VIS + V_FP + V_SYNC + V_BP,
    localparam int             HW        = $clog2(H_TOT),
    localparam int             VW        = $clog2(V_TOT)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [CW-1:0] COLOUR_INPUT,
    input  logic [1:0]    MASTER_STATE,
    output logic [HW-1:0] ADDRH,
    output logic [VW-1:0] ADDRV,
    output logic          PIXEL_EN,
    output logic          FRAME_START,
    output logic [CW-1:0] COLOUR_OUT,
    output logic          HS,
    output logic          VS
);
    localparam int              DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0]   H_LAST   = HW'(H_TOT - 1);
    localparam logic [HW-1:0]   H_VIS_W  = HW'(H_VIS);
    localparam logic [HW-1:0]   HS_BEG   = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0]   HS_END   = HW'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0]   V_LAST   = VW'(V_TOT - 1);
    localparam logic [VW-1:0]   V_VIS_W  = VW'(V_VIS);
    localparam logic [VW-1:0]   VS_BEG   = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0]   VS_END   = VW'(V_VIS + V_FP + V_SYNC - 1);

    logic [DW-1:0] div_q, div_d;
    logic          pix_en_q, pix_en_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic [7:0]    frame_q, frame_d;
    logic [1:0]    state_q, state_d;
    logic          vis_q, vis_d;
    logic          hs_raw_q, hs_raw_d;
    logic          vs_raw_q, vs_raw_d;
    logic [CW-1:0] colour_q, colour_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          frame_start;
    logic [11:0]   win_col;
    logic [CW-1:0] sel;

    assign frame_start = pix_en_q && (hcnt_q == '0) && (vcnt_q == '0);

    always_comb begin
        win_col = {frame_q[7:4], frame_q[7:4] ^ 4'hF, frame_q[3:0]};
        case (state_q)
            2'b00:   sel = COL_START;
            2'b01:   sel = COLOUR_INPUT;
            2'b10:   sel = CW'(win_col);
            default: sel = COL_LOSE;
        endcase

        // PIXEL_EN is registered so it stays low through reset even when CLK_DIV is 1
        div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        pix_en_d = (div_q == DIV_LAST);
        hcnt_d   = hcnt_q;
        vcnt_d   = vcnt_q;
        frame_d  = frame_q;
        state_d  = state_q;
        vis_d    = vis_q;
        hs_raw_d = hs_raw_q;
        vs_raw_d = vs_raw_q;
        colour_d = colour_q;
        hs_d     = hs_q;
        vs_d     = vs_q;

        if (pix_en_q) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                if (vcnt_q == V_LAST) begin
                    vcnt_d  = '0;
                    frame_d = frame_q + 8'd1;
                end else begin
                    vcnt_d = vcnt_q + 1'b1;
                end
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
            vis_d    = (hcnt_q < H_VIS_W) && (vcnt_q < V_VIS_W);
            hs_raw_d = (hcnt_q >= HS_BEG) && (hcnt_q <= HS_END);
            vs_raw_d = (vcnt_q >= VS_BEG) && (vcnt_q <= VS_END);
            colour_d = vis_q ? sel : '0;
            hs_d     = hs_raw_q ^ ~SYNC_POL;
            vs_d     = vs_raw_q ^ ~SYNC_POL;
        end

        if (frame_start) begin
            state_d = MASTER_STATE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            div_q    <= '0;
            pix_en_q <= 1'b0;
            hcnt_q   <= '0;
            vcnt_q   <= '0;
            frame_q  <= '0;
            state_q  <= 2'b00;
            vis_q    <= 1'b0;
            hs_raw_q <= 1'b0;
            vs_raw_q <= 1'b0;
            colour_q <= '0;
            hs_q     <= ~SYNC_POL;
            vs_q     <= ~SYNC_POL;
        end else begin
            div_q    <= div_d;
            pix_en_q <= pix_en_d;
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            frame_q  <= frame_d;
            state_q  <= state_d;
            vis_q    <= vis_d;
            hs_raw_q <= hs_raw_d;
            vs_raw_q <= vs_raw_d;
            colour_q <= colour_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
        end
    end

    assign ADDRH       = hcnt_q;
    assign ADDRV       = vcnt_q;
    assign PIXEL_EN    = pix_en_q;
    assign FRAME_START = frame_start;
    assign COLOUR_OUT  = colour_q;
    assign HS          = hs_q;
    assign VS          = vs_q;
endmodule

// File: tb/tb_vga_display_engine.sv
// Bench for vga_display_engine: a default 640x480 instance and a tiny 4x3 instance, both
// checked every cycle against a tick-count model, plus literal timing expectations.
module tb_vga_display_engine;
    localparam int P_HV  [2] = '{640, 4};
    localparam int P_HF  [2] = '{16, 1};
    localparam int P_HS  [2] = '{96, 1};
    localparam int P_HB  [2] = '{48, 1};
    localparam int P_VV  [2] = '{480, 3};
    localparam int P_VF  [2] = '{10, 1};
    localparam int P_VS  [2] = '{2, 1};
    localparam int P_VB  [2] = '{33, 1};
    localparam int P_DIV [2] = '{4, 1};
    localparam bit P_POL [2] = '{1'b0, 1'b1};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] cin = '0;
    logic [1:0]  mst = 2'b01;
    bit          rnd_en = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;

    logic [15:0] d_addrh [2];
    logic [15:0] d_addrv [2];
    logic        d_pe [2];
    logic        d_fs [2];
    logic        d_hs [2];
    logic        d_vs [2];
    logic [11:0] d_col [2];
    int          mk [2];
    logic [11:0] mcol [2];

    always #5 clk = ~clk;

    function automatic int f_ht(int g);
        return P_HV[g] + P_HF[g] + P_HS[g] + P_HB[g];
    endfunction
    function automatic int f_vt(int g);
        return P_VV[g] + P_VF[g] + P_VS[g] + P_VB[g];
    endfunction
    // pixel ticks completed after k clock edges since reset release
    function automatic int f_ticks(int g, int k);
        return (k < 1) ? 0 : (k - 1) / P_DIV[g];
    endfunction
    // frame number of the pixel on the outputs after n ticks
    function automatic int f_fidx(int g, int n);
        return (n < 2) ? 0 : ((n - 2) / (f_ht(g) * f_vt(g))) % 256;
    endfunction
    function automatic logic [11:0] f_colour(int g, int n, logic [11:0] c, logic [1:0] s);
        int p, h, v;
        logic [7:0] fr;
        if (n < 2) return '0;
        p  = (n - 2) % (f_ht(g) * f_vt(g));
        h  = p % f_ht(g);
        v  = p / f_ht(g);
        fr = 8'(f_fidx(g, n));
        if (h >= P_HV[g] || v >= P_VV[g]) return '0;
        case (s)
            2'b00:   return 12'h00F;
            2'b01:   return c;
            2'b10:   return {fr[7:4], ~fr[7:4], fr[3:0]};
            default: return 12'hF00;
        endcase
    endfunction
    function automatic logic f_sync(int g, int n, bit vert);
        int p, pos, beg, w;
        if (n < 2) return !P_POL[g];
        p   = (n - 2) % (f_ht(g) * f_vt(g));
        pos = vert ? p / f_ht(g) : p % f_ht(g);
        beg = vert ? P_VV[g] + P_VF[g] : P_HV[g] + P_HF[g];
        w   = vert ? P_VS[g] : P_HS[g];
        return (pos >= beg && pos < beg + w) ? P_POL[g] : !P_POL[g];
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int HT = P_HV[g] + P_HF[g] + P_HS[g] + P_HB[g];
        localparam int VT = P_VV[g] + P_VF[g] + P_VS[g] + P_VB[g];
        localparam int FT = HT * VT;
        localparam int HW = $clog2(HT);
        localparam int VW = $clog2(VT);
        logic [HW-1:0] addrh;
        logic [VW-1:0] addrv;
        logic          pe, fs, hs, vs;
        logic [11:0]   col;
        int            k = 0;
        logic [11:0]   m_col = '0;
        logic [1:0]    m_st [256];

        vga_display_engine #(
            .H_VIS(P_HV[g]), .H_FP(P_HF[g]), .H_SYNC(P_HS[g]), .H_BP(P_HB[g]),
            .V_VIS(P_VV[g]), .V_FP(P_VF[g]), .V_SYNC(P_VS[g]), .V_BP(P_VB[g]),
            .CLK_DIV(P_DIV[g]), .CW(12), .SYNC_POL(P_POL[g])
        ) u_dut (
            .CLK(clk), .RESET(rst), .COLOUR_INPUT(cin), .MASTER_STATE(mst),
            .ADDRH(addrh), .ADDRV(addrv), .PIXEL_EN(pe), .FRAME_START(fs),
            .COLOUR_OUT(col), .HS(hs), .VS(vs)
        );

        assign d_addrh[g] = 16'(addrh);
        assign d_addrv[g] = 16'(addrv);
        assign d_pe[g]    = pe;
        assign d_fs[g]    = fs;
        assign d_hs[g]    = hs;
        assign d_vs[g]    = vs;
        assign d_col[g]   = col;
        assign mk[g]      = k;
        assign mcol[g]    = m_col;

        // The state for a frame is whatever MASTER_STATE was on that frame's first tick.
        always @(posedge clk) begin
            if (rst) begin
                k     <= 0;
                m_col <= '0;
            end else begin
                k <= k + 1;
                if (k >= 1 && k % P_DIV[g] == 0) begin
                    if ((f_ticks(g, k + 1) - 1) % FT == 0)
                        m_st[((f_ticks(g, k + 1) - 1) / FT) % 256] <= mst;
                    m_col <= f_colour(g, f_ticks(g, k + 1), cin,
                                      m_st[f_fidx(g, f_ticks(g, k + 1))]);
                end
            end
        end
    end

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s inst%0d: got %0h, expected %0h at %0t", name, g, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int g = 0; g < 2; g++) begin
            int k, n, pos;
            logic e_pe;
            k    = mk[g];
            n    = f_ticks(g, k);
            pos  = n % (f_ht(g) * f_vt(g));
            e_pe = (k >= 1) && (k % P_DIV[g] == 0);
            chk("pixel_en", g, 32'(d_pe[g]), 32'(e_pe));
            chk("addrh", g, 32'(d_addrh[g]), 32'(pos % f_ht(g)));
            chk("addrv", g, 32'(d_addrv[g]), 32'(pos / f_ht(g)));
            chk("frame_start", g, 32'(d_fs[g]), 32'(e_pe && pos == 0));
            chk("colour", g, 32'(d_col[g]), 32'(mcol[g]));
            chk("hs", g, 32'(d_hs[g]), 32'(f_sync(g, n, 1'b0)));
            chk("vs", g, 32'(d_vs[g]), 32'(f_sync(g, n, 1'b1)));
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        compare_all();
        if (rnd_en) begin
            cin = 12'($urandom);
            if ($urandom_range(0, 40) == 0) mst = 2'($urandom);
        end
    endtask

    initial begin
        int fpa, fpb, cyc, nfs;
        int fa1, fa2, ra1, rb1, rb2, fb1, rvb, fvb, fs1, fs2;
        logic pa, pb, pvb;
        fpa = -1; fpb = -1; fa1 = -1; fa2 = -1; ra1 = -1; rb1 = -1; rb2 = -1;
        fb1 = -1; rvb = -1; fvb = -1; fs1 = -1; fs2 = -1; cyc = 0; nfs = 0;

        repeat (3) @(negedge clk);
        chk("rst_colour", 0, 32'(d_col[0]), 32'h0);
        chk("rst_hs", 0, 32'(d_hs[0]), 32'h1);
        chk("rst_vs", 0, 32'(d_vs[0]), 32'h1);
        chk("rst_hs", 1, 32'(d_hs[1]), 32'h0);
        chk("rst_pixel_en", 1, 32'(d_pe[1]), 32'h0);
        rst = 1'b0;

        for (int c = 1; c <= 10; c++) begin
            cycle();
            if (d_pe[0] && fpa < 0) fpa = c;
            if (d_pe[1] && fpb < 0) fpb = c;
        end
        chk("first_pixel_en", 0, 32'(fpa), 32'd4);
        chk("first_pixel_en", 1, 32'(fpb), 32'd1);

        rnd_en = 1'b1;
        for (int i = 0; i < 9000 && f_ticks(0, mk[0]) != 1900; i++) begin
            pa = d_hs[0]; pb = d_hs[1]; pvb = d_vs[1];
            cycle();
            cyc++;
            if (pa && !d_hs[0]) begin
                if (fa1 < 0) fa1 = cyc; else if (fa2 < 0) fa2 = cyc;
            end
            if (!pa && d_hs[0] && fa1 >= 0 && ra1 < 0) ra1 = cyc;
            if (!pb && d_hs[1]) begin
                if (rb1 < 0) rb1 = cyc; else if (rb2 < 0) rb2 = cyc;
            end
            if (pb && !d_hs[1] && rb1 >= 0 && fb1 < 0) fb1 = cyc;
            if (!pvb && d_vs[1] && rvb < 0) rvb = cyc;
            if (pvb && !d_vs[1] && rvb >= 0 && fvb < 0) fvb = cyc;
            if (d_fs[1]) begin
                if (fs1 < 0) fs1 = cyc; else if (fs2 < 0) fs2 = cyc;
            end
        end
        chk("hs_low_cycles", 0, 32'(ra1 - fa1), 32'd384);
        chk("hs_period_cycles", 0, 32'(fa2 - fa1), 32'd3200);
        chk("hs_high_cycles", 1, 32'(fb1 - rb1), 32'd1);
        chk("hs_period_cycles", 1, 32'(rb2 - rb1), 32'd7);
        chk("vs_high_cycles", 1, 32'(fvb - rvb), 32'd7);
        chk("frame_start_period", 1, 32'(fs2 - fs1), 32'd42);

        chk("pre_reset_addrh", 0, 32'(d_addrh[0]), 32'd300);
        chk("pre_reset_addrv", 0, 32'(d_addrv[0]), 32'd2);
        rnd_en = 1'b0;
        rst = 1'b1;
        cycle();
        chk("mid_reset_addrh", 0, 32'(d_addrh[0]), 32'd0);
        chk("mid_reset_addrv", 0, 32'(d_addrv[0]), 32'd0);
        chk("mid_reset_colour", 0, 32'(d_col[0]), 32'h0);
        chk("mid_reset_hs", 0, 32'(d_hs[0]), 32'h1);
        chk("mid_reset_vs", 0, 32'(d_vs[0]), 32'h1);
        rst = 1'b0;
        rnd_en = 1'b1;

        repeat (11000) cycle();

        rnd_en = 1'b0;
        cin = 12'hABC;
        mst = 2'b01;
        for (int i = 0; i < 200 && nfs < 2; i++) begin
            cycle();
            if (d_fs[1]) nfs++;
        end
        chk("wait_frames", 1, 32'(nfs), 32'd2);
        for (int i = 0; i < 50 && d_addrv[1] != 16'd1; i++) cycle();
        mst = 2'b11;
        for (int i = 0; i < 50 && !(d_addrv[1] == 16'd2 && d_addrh[1] == 16'd3); i++) cycle();
        chk("old_state_colour", 1, 32'(d_col[1]), 32'hABC);
        nfs = 0;
        for (int i = 0; i < 60 && nfs < 1; i++) begin
            cycle();
            if (d_fs[1]) nfs++;
        end
        for (int i = 0; i < 10 && !(d_addrv[1] == 16'd0 && d_addrh[1] == 16'd3); i++) cycle();
        chk("new_state_colour", 1, 32'(d_col[1]), 32'hF00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
